// File: rtl/breakout_pkg.sv
// Shared types and playfield constants for the breakout brick logic.
package breakout_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PLAY,
        ST_COOL,
        ST_WIN,
        ST_LOSE
    } hit_state_t;

    localparam int SCREEN_W     = 640;
    localparam int SCREEN_H     = 480;
    localparam int BALL_RADIUS  = 4;
    localparam int BRICK_HALF_W = 16;
    localparam int BRICK_HALF_H = 8;
    localparam int MAX_BLOCKS   = 32;
    localparam int BLK_CNT_W    = 6;

endpackage

// File: rtl/block_hit_collector_popcount_n.sv
// Combinational population count of a flag vector.
module popcount_n #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 6
) (
    input  logic [WIDTH-1:0] vec_i,
    output logic [CNT_W-1:0] cnt_o
);

    always_comb begin
        cnt_o = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_o = cnt_o + CNT_W'(vec_i[i]);
        end
    end

endmodule

// File: rtl/block_hit_collector.sv
// Turns brick collision/status flags into one-shot ball deflections, score and game status.
// Define CORNER_FLIP_EN to flip both axes on a corner contact (default: flip_y only).
module block_hit_collector
    import breakout_pkg::*;
#(
    parameter int N_BLOCKS      = 8,
    parameter int SCORE_W       = 12,
    parameter int PTS_PER_BLOCK = 10,
    parameter int COOLDOWN      = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic [N_BLOCKS-1:0] exist,
    input  logic [N_BLOCKS-1:0] hit_u,
    input  logic [N_BLOCKS-1:0] hit_d,
    input  logic [N_BLOCKS-1:0] hit_l,
    input  logic [N_BLOCKS-1:0] hit_r,
    input  logic [N_BLOCKS-1:0] endgame_block,
    output logic                flip_x,
    output logic                flip_y,
    output logic [SCORE_W-1:0]  score,
    output logic [5:0]          blocks_left,
    output logic                win,
    output logic                lose,
    output logic                endgame
);

    localparam int CD_W  = (COOLDOWN > 2) ? $clog2(COOLDOWN) : 1;
    localparam int SUM_W = SCORE_W + 16;

    logic [N_BLOCKS-1:0]  hit_vec;
    logic [BLK_CNT_W-1:0] hit_cnt;
    logic [BLK_CNT_W-1:0] exist_cnt;
    logic                 live_end;
    logic                 vhit;
    logic                 hhit;
    logic                 any_hit;
    logic                 none_left;

    hit_state_t           state_q;
    logic [CD_W-1:0]      cnt_q;
    logic                 flip_x_q;
    logic                 flip_y_q;
    logic                 win_q;
    logic                 lose_q;
    logic [SCORE_W-1:0]   score_q;
    logic [5:0]           blocks_left_q;

    logic                 flip_x_d;
    logic [SCORE_W-1:0]   score_d;

    function automatic logic [SCORE_W-1:0] sat_add_score(
        input logic [SCORE_W-1:0]   base,
        input logic [BLK_CNT_W-1:0] n
    );
        logic [SUM_W-1:0] sum;
        sum = SUM_W'(base) + SUM_W'(PTS_PER_BLOCK) * SUM_W'(n);
        if (sum > SUM_W'({SCORE_W{1'b1}})) begin
            return '1;
        end
        return sum[SCORE_W-1:0];
    endfunction

    // Dead bricks keep reporting stale contact flags, so everything is masked by exist.
    assign hit_vec   = (hit_u | hit_d | hit_l | hit_r) & exist;
    assign vhit      = |((hit_u | hit_d) & exist);
    assign hhit      = |((hit_l | hit_r) & exist);
    assign any_hit   = vhit | hhit;
    assign live_end  = |(endgame_block & exist);
    assign none_left = (exist == '0);

`ifdef CORNER_FLIP_EN
    assign flip_x_d = hhit;
`else
    assign flip_x_d = hhit & ~vhit;
`endif

    assign score_d = sat_add_score(score_q, hit_cnt);

    popcount_n #(.WIDTH(N_BLOCKS), .CNT_W(BLK_CNT_W)) u_hit_cnt (
        .vec_i (hit_vec),
        .cnt_o (hit_cnt)
    );

    popcount_n #(.WIDTH(N_BLOCKS), .CNT_W(BLK_CNT_W)) u_exist_cnt (
        .vec_i (exist),
        .cnt_o (exist_cnt)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            flip_x_q      <= 1'b0;
            flip_y_q      <= 1'b0;
            score_q       <= '0;
            blocks_left_q <= '0;
            win_q         <= 1'b0;
            lose_q        <= 1'b0;
        end else begin
            flip_x_q      <= 1'b0;
            flip_y_q      <= 1'b0;
            blocks_left_q <= exist_cnt;
            case (state_q)
                ST_IDLE: begin
                    if (start) state_q <= ST_PLAY;
                end
                ST_PLAY: begin
                    if (!start) begin
                        state_q <= ST_IDLE;
                    end else if (live_end) begin
                        state_q <= ST_LOSE;
                        lose_q  <= 1'b1;
                    end else if (none_left) begin
                        state_q <= ST_WIN;
                        win_q   <= 1'b1;
                    end else if (any_hit) begin
                        flip_x_q <= flip_x_d;
                        flip_y_q <= vhit;
                        score_q  <= score_d;
                        cnt_q    <= CD_W'(COOLDOWN - 1);
                        state_q  <= ST_COOL;
                    end
                end
                ST_COOL: begin
                    // Hits are ignored here so a flag held over several cycles counts once.
                    if (!start) begin
                        state_q <= ST_IDLE;
                    end else if (live_end) begin
                        state_q <= ST_LOSE;
                        lose_q  <= 1'b1;
                    end else if (cnt_q == '0) begin
                        if (none_left) begin
                            state_q <= ST_WIN;
                            win_q   <= 1'b1;
                        end else begin
                            state_q <= ST_PLAY;
                        end
                    end else begin
                        cnt_q <= cnt_q - CD_W'(1);
                    end
                end
                ST_WIN, ST_LOSE: ;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign flip_x      = flip_x_q;
    assign flip_y      = flip_y_q;
    assign score       = score_q;
    assign blocks_left = blocks_left_q;
    assign win         = win_q;
    assign lose        = lose_q;
    assign endgame     = win_q | lose_q;

endmodule

// File: tb/tb_block_hit_collector.sv
// Scoreboard bench for block_hit_collector with a cycle-level reference model.
module tb_block_hit_collector;

    localparam int N   = 8;
    localparam int SW  = 12;
    localparam int PTS = 10;
    localparam int CD  = 4;

    logic          clock;
    logic          rst_n;
    logic          start;
    logic [N-1:0]  exist, hu, hd, hl, hr, eb;
    logic          flip_x, flip_y, win, lose, endgame;
    logic [SW-1:0] score;
    logic [5:0]    blocks_left;

    block_hit_collector #(
        .N_BLOCKS(N), .SCORE_W(SW), .PTS_PER_BLOCK(PTS), .COOLDOWN(CD)
    ) dut (
        .clock         (clock),
        .reset         (rst_n),
        .start         (start),
        .exist         (exist),
        .hit_u         (hu),
        .hit_d         (hd),
        .hit_l         (hl),
        .hit_r         (hr),
        .endgame_block (eb),
        .flip_x        (flip_x),
        .flip_y        (flip_y),
        .score         (score),
        .blocks_left   (blocks_left),
        .win           (win),
        .lose          (lose),
        .endgame       (endgame)
    );

    typedef struct {
        int   due;
        logic fx, fy, w, l, e;
        int   sc;
        int   bl;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    // Reference model: game phase flags plus a count of suppressed cycles.
    bit m_run, m_won, m_lost;
    int m_quiet, m_score;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc++;

    function automatic exp_t rst_exp(int due);
        exp_t e;
        e.due = due; e.fx = 0; e.fy = 0; e.w = 0; e.l = 0; e.e = 0; e.sc = 0; e.bl = 0;
        return e;
    endfunction

    task automatic model_step(output exp_t e);
        bit live, v, h, any;
        int n;
        e = rst_exp(0);
        if (!rst_n) begin
            m_run = 0; m_won = 0; m_lost = 0; m_quiet = 0; m_score = 0;
            return;
        end
        if (m_won || m_lost) begin
        end else if (!m_run) begin
            if (start) m_run = 1;
        end else if (!start) begin
            m_run = 0;
            m_quiet = 0;
        end else begin
            live = 0;
            for (int i = 0; i < N; i++) if (eb[i] && exist[i]) live = 1;
            if (live) begin
                m_lost = 1;
            end else if (m_quiet > 0) begin
                m_quiet--;
                if (m_quiet == 0 && exist == 0) m_won = 1;
            end else if (exist == 0) begin
                m_won = 1;
            end else begin
                v = 0; h = 0; n = 0;
                for (int i = 0; i < N; i++) begin
                    if (exist[i]) begin
                        any = 0;
                        if (hu[i] || hd[i]) begin v = 1; any = 1; end
                        if (hl[i] || hr[i]) begin h = 1; any = 1; end
                        if (any) n++;
                    end
                end
                if (n > 0) begin
                    e.fy = v;
`ifdef CORNER_FLIP_EN
                    e.fx = h;
`else
                    e.fx = h && !v;
`endif
                    m_score = m_score + PTS * n;
                    if (m_score > (1 << SW) - 1) m_score = (1 << SW) - 1;
                    m_quiet = CD;
                end
            end
        end
        e.sc = m_score;
        e.bl = $countones(exist);
        e.w  = m_won;
        e.l  = m_lost;
        e.e  = m_won || m_lost;
    endtask

    // Inputs set before the call are sampled at the next rising edge.
    task automatic tick();
        exp_t e;
        model_step(e);
        e.due = cyc + 1;
        // Asynchronous reset clears outputs already in flight for the current cycle.
        if (!rst_n && q.size() > 0 && q[q.size()-1].due == cyc) q[q.size()-1] = rst_exp(cyc);
        q.push_back(e);
        @(posedge clock);
        #1;
    endtask

    task automatic clr_hits();
        hu = '0; hd = '0; hl = '0; hr = '0; eb = '0;
    endtask

    task automatic restart(input logic [N-1:0] ex);
        rst_n = 1'b0; start = 1'b0; exist = ex; clr_hits();
        tick();
        rst_n = 1'b1; start = 1'b1;
        tick();
        tick();
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clock);
            while (q.size() > 0 && q[0].due <= cyc) begin
                e = q.pop_front();
                n_tests++;
                if (flip_x !== e.fx || flip_y !== e.fy || score !== SW'(e.sc) ||
                    blocks_left !== 6'(e.bl) || win !== e.w || lose !== e.l || endgame !== e.e) begin
                    n_fail++;
                    $display("FAIL outputs cyc %0d: got fx=%0b fy=%0b score=%0d left=%0d win=%0b lose=%0b end=%0b, need fx=%0b fy=%0b score=%0d left=%0d win=%0b lose=%0b end=%0b",
                             e.due, flip_x, flip_y, score, blocks_left, win, lose, endgame,
                             e.fx, e.fy, e.sc, e.bl, e.w, e.l, e.e);
                end
            end
        end
    end

    initial begin : stim
        int wait_cyc;
        rst_n = 1'b0; start = 1'b0; exist = '0; clr_hits();
        tick();
        tick();
        rst_n = 1'b1; start = 1'b1; exist = 8'hFF;
        repeat (3) tick();

        hd[3] = 1'b1;
        repeat (2) tick();
        clr_hits();
        repeat (6) tick();

        hu[1] = 1'b1; hu[2] = 1'b1;
        tick();
        clr_hits();
        repeat (6) tick();

        hu[0] = 1'b1; hl[0] = 1'b1;
        tick();
        clr_hits();
        repeat (6) tick();

        hr[6] = 1'b1;
        tick();
        clr_hits();
        repeat (2) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        hl[4] = 1'b1;
        tick();
        clr_hits();
        repeat (6) tick();

        for (int i = 0; i < N; i++) begin
            exist[i] = 1'b0;
            repeat (2) tick();
        end
        hu = 8'hFF; hl = 8'hFF;
        repeat (3) tick();
        clr_hits();
        tick();

        restart(8'hFF);
        hd[2] = 1'b1;
        tick();
        clr_hits();
        exist = '0;
        repeat (7) tick();

        restart(8'hFF);
        eb[5] = 1'b1; hr[2] = 1'b1;
        tick();
        clr_hits();
        repeat (3) tick();

        restart(8'hDF);
        eb[5] = 1'b1;
        repeat (4) tick();
        hr[2] = 1'b1;
        tick();
        hr[2] = 1'b0;
        repeat (6) tick();

        restart(8'hFF);
        hu = 8'hFF;
        repeat (300) tick();
        clr_hits();
        tick();

        for (int ep = 0; ep < 20; ep++) begin
            restart(8'hFF);
            for (int c = 0; c < 150; c++) begin
                rst_n = ($urandom_range(0, 199) != 0);
                start = ($urandom_range(0, 29) != 0);
                if ($urandom_range(0, 9) == 0) exist[$urandom_range(0, N-1)] = 1'b0;
                hu = ($urandom_range(0, 5) == 0) ? N'($urandom) : '0;
                hd = ($urandom_range(0, 5) == 0) ? N'($urandom) : '0;
                hl = ($urandom_range(0, 5) == 0) ? N'($urandom) : '0;
                hr = ($urandom_range(0, 5) == 0) ? N'($urandom) : '0;
                eb = ($urandom_range(0, 60) == 0) ? N'($urandom) : '0;
                tick();
            end
        end

        rst_n = 1'b1; clr_hits();
        wait_cyc = 0;
        while (q.size() > 0 && wait_cyc < 10) begin
            @(posedge clock);
            wait_cyc++;
        end
        @(negedge clock);
        #1;
        if (q.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d expected outputs never presented, need 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
